pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control unit and sole producer of the 6-bit stall vector consumed by every inter-stage register (pc, if_id, id_ex, ex_mem, mem_wb).
- Also producer of the flush pulse and redirect PC.
- Arbitrates per-stage stall requests and exception/ERET redirects.
- Tracks consecutive-stall duration with a watchdog.
- Sits beside the pipeline; outputs fan out to all stage registers and the PC unit.

Parameters:
- EXC_VECTOR, 32'h0000_0020, redirect PC for any exception other than ERET.
- ERET_CODE, 32'h0000_000E, excp_type value meaning ERET (redirect to cp0_epc).
- MAX_STALL, 16'd1024, consecutive stalled cycles that trigger a watchdog event (legal range 2..65535).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stallreq_if  in  1  IF stage requests stall.
- stallreq_id  in  1  ID stage requests stall (load-use hazard).
- stallreq_ex  in  1  EX stage requests stall (multi-cycle op).
- stallreq_mem  in  1  MEM stage requests stall (bus wait).
- excp_valid  in  1  exception/ERET committed in MEM this cycle.
- excp_type  in  32  exception code, valid with excp_valid.
- cp0_epc  in  32  EPC from CP0.
- wd_clear  in  1  clears sticky watchdog status.
- stall  out  6  [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB; 1=stop.
- flush  out  1  clear all stage registers this edge.
- new_pc  out  32  redirect target, valid with flush.
- stall_timeout  out  1  one-cycle watchdog pulse.
- stall_timeout_sticky  out  1  latched watchdog status.
- perf_stall_cycles  out  32  total stalled cycles (optional feature).
- perf_flush_count  out  32  total flushes (optional feature).

Behaviour:
- stall, flush and new_pc are combinational from the inputs, with the same-cycle response the stage registers rely on. All other state is registered.
- Priority and stall encoding:
  - rst=1: stall=0, flush=0, new_pc=0.
  - Else excp_valid=1: flush=1, stall=6'b000000, new_pc = (excp_type==ERET_CODE) ? cp0_epc : EXC_VECTOR.
  - Else stallreq_mem=1: stall=6'b011111.
  - Else stallreq_ex=1: stall=6'b001111.
  - Else stallreq_id=1: stall=6'b000111.
  - Else stallreq_if=1: stall=6'b000011.
  - Else stall=0.
  - flush=0 and new_pc=0 whenever excp_valid=0.
- Invariant: stall is always of the form 0..01..1. The boundary stage N is stalled and stage N+1 is not, so that stage register inserts a bubble.
- FSM, states RUN and STALLED, reset to RUN:
  - RUN -> STALLED when stall!=0 at the clock edge.
  - STALLED -> RUN when stall==0 or flush=1.
  - Flush always wins over any stall request and returns the FSM to RUN.
- Watchdog:
  - 16-bit run_cnt: reset 0. Cleared when the FSM is in or enters RUN. Otherwise incremented on each stalled edge.
  - When run_cnt reaches MAX_STALL-1 and stall!=0: stall_timeout=1 for exactly one cycle (registered, visible the cycle after) and run_cnt wraps to 0.
  - A stall held 3*MAX_STALL cycles yields 3 pulses.
  - stall_timeout_sticky is set by the pulse and cleared by wd_clear or rst. Simultaneous set and clear: set wins.
  - The watchdog never releases stall; it only reports.
- A change of cause mid-stall (e.g. id -> ex with no gap) keeps the FSM in STALLED and does not reset run_cnt.
- rst asserted mid-stall: all registers return to reset values on that edge. Outputs reset: stall_timeout=0, stall_timeout_sticky=0, perf counters=0.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined:
  - perf_stall_cycles increments every non-reset edge with stall!=0.
  - perf_flush_count increments every edge with flush=1.
  - Both 32-bit, wrap 0xFFFF_FFFF -> 0.
  - Neither is affected by wd_clear.
- Undefined: both outputs are constant 0 and no counter registers exist.

Test Plan:
- Reset, then idle 5 cycles -> stall=6'b000000, flush=0, new_pc=0, stall_timeout=0.
- stallreq_id=1 for 3 cycles, then stallreq_ex=1 with stallreq_id=1 -> stall=000111 for 3 cycles then 001111. With PERF_EN, perf_stall_cycles advances by 1 per stalled cycle.
- stallreq_mem=1 and excp_valid=1 with excp_type=0x0C -> flush=1, stall=0, new_pc=0x20. Next cycle with excp_valid=0, stall=011111. Then ERET (excp_type=0x0E, cp0_epc=0x8000_1234) -> new_pc=0x8000_1234.
- MAX_STALL=4, stallreq_ex held 9 cycles -> stall_timeout pulses on cycles 5 and 9 (1-based, registered). Sticky=1 until wd_clear; wd_clear coincident with a pulse leaves sticky=1.
- rst asserted on cycle 3 of a 10-cycle stall -> FSM in RUN, run_cnt=0, sticky=0; the stall vector follows the still-held request on the first cycle after rst deasserts.

Source files
------------

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- pipeline control unit
//
// Purpose:
//   This is the only block that drives the stall vector for the inter-stage
//   registers (pc, if_id, id_ex, ex_mem, mem_wb). It also drives the flush
//   pulse and the redirect PC. It arbitrates the per-stage stall requests
//   against exception/ERET redirects. A watchdog measures how long a stall
//   has lasted without a break. The watchdog only reports; it never releases
//   a stall.
//
// Configuration:
//   PIPE_CTRL_PERF_EN -- when defined, adds free-running 32-bit counters for
//                        stalled cycles and flushes. When undefined, the
//                        perf outputs are tied to 0 and no counters exist.
//
// Parameters:
//   EXC_VECTOR  redirect PC for every exception except ERET
//   ERET_CODE   excp_type value that means ERET (redirect to cp0_epc)
//   MAX_STALL   number of consecutive stalled cycles per watchdog event
//               (legal range 2..65535)
//
// Ports:
//   clk                   clock
//   rst                   synchronous active-high reset
//   stallreq_if/id/ex/mem per-stage stall requests
//   excp_valid            exception/ERET committed in MEM this cycle
//   excp_type             exception code, qualified by excp_valid
//   cp0_epc               EPC from CP0 (ERET target)
//   wd_clear              clears the sticky watchdog status
//   stall[5:0]            [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB, 1=hold
//   flush                 clear all stage registers on this edge
//   new_pc                redirect target, valid with flush
//   stall_timeout         one-cycle watchdog pulse (registered)
//   stall_timeout_sticky  latched watchdog status
//   perf_stall_cycles     total stalled cycles (optional)
//   perf_flush_count      total flushes (optional)
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter logic [31:0] ERET_CODE  = 32'h0000_000E,
    parameter logic [15:0] MAX_STALL  = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        excp_valid,
    input  logic [31:0] excp_type,
    input  logic [31:0] cp0_epc,
    input  logic        wd_clear,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout,
    output logic        stall_timeout_sticky,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_STALLED = 1'b1
    } state_t;

    // Last run_cnt value before the watchdog fires.
    localparam logic [15:0] WD_LAST = MAX_STALL - 16'd1;

    // -----------------------------------------------------------------------
    // Combinational arbitration
    // -----------------------------------------------------------------------
    // stall_depth is the number of low-order stall bits that are set. The
    // stall vector is always a thermometer code, so the first stage that is
    // not held takes a bubble from the stage behind it.
    logic [2:0] stall_depth;
    logic       stalled;

    always_comb begin
        stall_depth = 3'd0;
        flush       = 1'b0;
        new_pc      = 32'h0000_0000;
        if (rst) begin
            stall_depth = 3'd0;
        end else if (excp_valid) begin
            // The redirect takes priority over every stall request. All
            // stages are cleared, so there is nothing left to hold.
            flush  = 1'b1;
            new_pc = (excp_type == ERET_CODE) ? cp0_epc : EXC_VECTOR;
        end else if (stallreq_mem) begin
            stall_depth = 3'd5;     // PC..MEM held, WB takes the bubble
        end else if (stallreq_ex) begin
            stall_depth = 3'd4;     // PC..EX held
        end else if (stallreq_id) begin
            stall_depth = 3'd3;     // PC..ID held
        end else if (stallreq_if) begin
            stall_depth = 3'd2;     // PC, IF held
        end
    end

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_stall_bit
            assign stall[gi] = (stall_depth > 3'(gi));
        end
    endgenerate

    assign stalled = (stall != 6'b000000);

    // -----------------------------------------------------------------------
    // FSM and watchdog next-state
    // -----------------------------------------------------------------------
    state_t      state_q;
    state_t      state_d;
    logic [15:0] run_cnt_q;
    logic [15:0] run_cnt_d;
    logic [15:0] run_base;
    logic        timeout_q;
    logic        timeout_d;
    logic        sticky_q;
    logic        sticky_d;

    always_comb begin
        // A flush forces stall to zero, so "not stalled" covers both exits
        // from STALLED.
        state_d   = stalled ? ST_STALLED : ST_RUN;

        // In RUN the count restarts, so the first stalled edge counts as 1.
        run_base  = (state_q == ST_RUN) ? 16'd0 : run_cnt_q;

        run_cnt_d = 16'd0;
        timeout_d = 1'b0;
        if (stalled) begin
            if (run_base == WD_LAST) begin
                // Wrapping lets a long stall report once every MAX_STALL
                // cycles instead of only once.
                run_cnt_d = 16'd0;
                timeout_d = 1'b1;
            end else begin
                run_cnt_d = run_base + 16'd1;
            end
        end

        // A set wins over a clear. A clear issued while the pulse is still
        // visible also loses, so software cannot erase an event it has
        // not yet had a cycle to observe.
        sticky_d = timeout_d | timeout_q | (sticky_q & ~wd_clear);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            run_cnt_q <= 16'd0;
            timeout_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            timeout_q <= timeout_d;
            sticky_q  <= sticky_d;
        end
    end

    assign stall_timeout        = timeout_q;
    assign stall_timeout_sticky = sticky_q;

    // -----------------------------------------------------------------------
    // Optional performance counters
    // -----------------------------------------------------------------------
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            // Both counters wrap naturally from 0xFFFF_FFFF to 0.
            if (stalled) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_count  = perf_flush_q;
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl (MAX_STALL = 4)
//
// Each task drives inputs on the falling edge and pushes the expected
// outputs for that cycle into a queue. A monitor pops the queue 1 time unit
// after the falling edge and compares every output. The tasks also check
// the key values from the test plan inline.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam logic [15:0] MAXS = 16'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_if = 1'b0;
    logic        stallreq_id = 1'b0;
    logic        stallreq_ex = 1'b0;
    logic        stallreq_mem = 1'b0;
    logic        excp_valid = 1'b0;
    logic [31:0] excp_type = 32'h0;
    logic [31:0] cp0_epc = 32'h0;
    logic        wd_clear = 1'b0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic        stall_timeout_sticky;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;

    always #5 clk = ~clk;

    pipe_ctrl #(.MAX_STALL(MAXS)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .stallreq_if          (stallreq_if),
        .stallreq_id          (stallreq_id),
        .stallreq_ex          (stallreq_ex),
        .stallreq_mem         (stallreq_mem),
        .excp_valid           (excp_valid),
        .excp_type            (excp_type),
        .cp0_epc              (cp0_epc),
        .wd_clear             (wd_clear),
        .stall                (stall),
        .flush                (flush),
        .new_pc               (new_pc),
        .stall_timeout        (stall_timeout),
        .stall_timeout_sticky (stall_timeout_sticky),
        .perf_stall_cycles    (perf_stall_cycles),
        .perf_flush_count     (perf_flush_count)
    );

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        to;
        logic        sticky;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_txn = 0;

    // Reference model state, as seen just before the next rising edge.
    int          m_cnt = 0;
    logic        m_to = 1'b0;
    logic        m_sticky = 1'b0;
    logic [31:0] m_ps = 32'h0;
    logic [31:0] m_pf = 32'h0;

    // req = {mem, ex, id, if}
    task automatic drive(input logic r, input logic [3:0] req, input logic ev,
                         input logic [31:0] et, input logic [31:0] epc,
                         input logic wdc);
        exp_t        e;
        logic [5:0]  s;
        logic        fl;
        logic [31:0] np;
        logic        nto;
        @(negedge clk);
        rst = r;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
        excp_valid = ev;
        excp_type  = et;
        cp0_epc    = epc;
        wd_clear   = wdc;

        s  = 6'b000000;
        fl = 1'b0;
        np = 32'h0;
        if (!r) begin
            if (ev) begin
                fl = 1'b1;
                np = (et == 32'h0000_000E) ? epc : 32'h0000_0020;
            end else if (req[3]) s = 6'b011111;
            else if (req[2]) s = 6'b001111;
            else if (req[1]) s = 6'b000111;
            else if (req[0]) s = 6'b000011;
        end
        e.stall  = s;
        e.flush  = fl;
        e.new_pc = np;
        e.to     = m_to;
        e.sticky = m_sticky;
`ifdef PIPE_CTRL_PERF_EN
        e.ps = m_ps;
        e.pf = m_pf;
`else
        e.ps = 32'h0;
        e.pf = 32'h0;
`endif
        sb_q.push_back(e);

        // Advance the model across the coming rising edge.
        if (r) begin
            m_cnt = 0; m_to = 1'b0; m_sticky = 1'b0; m_ps = 32'h0; m_pf = 32'h0;
        end else begin
            nto = 1'b0;
            if (s == 6'b000000) begin
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
                if (m_cnt == int'(MAXS)) begin
                    m_cnt = 0;
                    nto = 1'b1;
                end
            end
            m_sticky = nto | m_to | (m_sticky & ~wdc);
            m_to = nto;
            if (s != 6'b000000) m_ps = m_ps + 32'd1;
            if (fl) m_pf = m_pf + 32'd1;
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_txn++;
            n_vec++;
            $display("txn %0d: rst=%b req=%b%b%b%b ev=%b stall=%b flush=%b new_pc=%h to=%b sticky=%b",
                     n_txn, rst, stallreq_mem, stallreq_ex, stallreq_id, stallreq_if,
                     excp_valid, stall, flush, new_pc, stall_timeout, stall_timeout_sticky);
            if (stall !== mon_e.stall) begin
                n_err++; $display("FAIL sb_stall txn %0d: got %b expected %b", n_txn, stall, mon_e.stall);
            end
            if (flush !== mon_e.flush) begin
                n_err++; $display("FAIL sb_flush txn %0d: got %b expected %b", n_txn, flush, mon_e.flush);
            end
            if (new_pc !== mon_e.new_pc) begin
                n_err++; $display("FAIL sb_new_pc txn %0d: got %h expected %h", n_txn, new_pc, mon_e.new_pc);
            end
            if (stall_timeout !== mon_e.to) begin
                n_err++; $display("FAIL sb_timeout txn %0d: got %b expected %b", n_txn, stall_timeout, mon_e.to);
            end
            if (stall_timeout_sticky !== mon_e.sticky) begin
                n_err++; $display("FAIL sb_sticky txn %0d: got %b expected %b", n_txn, stall_timeout_sticky, mon_e.sticky);
            end
            if (perf_stall_cycles !== mon_e.ps) begin
                n_err++; $display("FAIL sb_perf_stall txn %0d: got %0d expected %0d", n_txn, perf_stall_cycles, mon_e.ps);
            end
            if (perf_flush_count !== mon_e.pf) begin
                n_err++; $display("FAIL sb_perf_flush txn %0d: got %0d expected %0d", n_txn, perf_flush_count, mon_e.pf);
            end
        end
    end

    task automatic test_reset();
        drive(1'b1, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
            #1;
            n_vec++;
            if (stall !== 6'b000000 || flush !== 1'b0 || new_pc !== 32'h0 || stall_timeout !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle c%0d: got stall=%b flush=%b new_pc=%h to=%b expected 000000/0/0/0",
                         c, stall, flush, new_pc, stall_timeout);
            end
        end
    endtask

    task automatic test_stall_priority();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 4'b0010, 1'b0, 32'h0, 32'h0, 1'b0);
            #1; n_vec++;
            if (stall !== 6'b000111) begin
                n_err++; $display("FAIL stall_id c%0d: got %b expected 000111", c, stall);
            end
        end
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 4'b0110, 1'b0, 32'h0, 32'h0, 1'b0);
            #1; n_vec++;
            if (stall !== 6'b001111) begin
                n_err++; $display("FAIL stall_ex c%0d: got %b expected 001111", c, stall);
            end
        end
        drive(1'b0, 4'b0001, 1'b0, 32'h0, 32'h0, 1'b0);
        #1; n_vec++;
        if (stall !== 6'b000011) begin
            n_err++; $display("FAIL stall_if: got %b expected 000011", stall);
        end
        drive(1'b0, 4'b1111, 1'b0, 32'h0, 32'h0, 1'b0);
        #1; n_vec++;
        if (stall !== 6'b011111) begin
            n_err++; $display("FAIL stall_mem: got %b expected 011111", stall);
        end
        drive(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b1);
        drive(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b1);
        drive(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_exception();
        drive(1'b0, 4'b1000, 1'b1, 32'h0000_000C, 32'h0, 1'b0);
        #1; n_vec++;
        if (flush !== 1'b1 || stall !== 6'b000000 || new_pc !== 32'h0000_0020) begin
            n_err++; $display("FAIL excp_vector: got flush=%b stall=%b new_pc=%h expected 1/000000/00000020", flush, stall, new_pc);
        end
        drive(1'b0, 4'b1000, 1'b0, 32'h0000_000C, 32'h0, 1'b0);
        #1; n_vec++;
        if (flush !== 1'b0 || stall !== 6'b011111 || new_pc !== 32'h0) begin
            n_err++; $display("FAIL excp_after: got flush=%b stall=%b new_pc=%h expected 0/011111/00000000", flush, stall, new_pc);
        end
        drive(1'b0, 4'b1000, 1'b1, 32'h0000_000E, 32'h8000_1234, 1'b0);
        #1; n_vec++;
        if (flush !== 1'b1 || new_pc !== 32'h8000_1234) begin
            n_err++; $display("FAIL eret: got flush=%b new_pc=%h expected 1/80001234", flush, new_pc);
        end
        drive(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_watchdog();
        logic exp_to;
        logic exp_sticky;
        int   pulses;
        drive(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b1);
        drive(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
        // stallreq_ex held 9 cycles; wd_clear on cycle 5 (with pulse) and cycle 6
        for (int c = 1; c <= 9; c++) begin
            drive(1'b0, 4'b0100, 1'b0, 32'h0, 32'h0, (c == 5 || c == 6));
            #1;
            exp_to     = (c == 5 || c == 9);
            exp_sticky = (c == 5 || c == 6 || c == 9);
            n_vec++;
            if (stall_timeout !== exp_to) begin
                n_err++; $display("FAIL wd_pulse cycle %0d: got %b expected %b", c, stall_timeout, exp_to);
            end
            n_vec++;
            if (stall_timeout_sticky !== exp_sticky) begin
                n_err++; $display("FAIL wd_sticky cycle %0d: got %b expected %b", c, stall_timeout_sticky, exp_sticky);
            end
        end
        drive(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b1);
        drive(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
        // 3*MAX_STALL stalled cycles yield three pulses (last one seen on the idle cycle)
        pulses = 0;
        for (int c = 1; c <= 13; c++) begin
            drive(1'b0, (c <= 12) ? 4'b1000 : 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
            #1;
            if (stall_timeout === 1'b1) pulses++;
        end
        n_vec++;
        if (pulses != 3) begin
            n_err++; $display("FAIL wd_three_pulses: got %0d expected 3", pulses);
        end
    endtask

    task automatic test_reset_mid_stall();
        // Sticky is still set from the previous task.
        for (int c = 1; c <= 10; c++) begin
            drive((c == 3), 4'b0100, 1'b0, 32'h0, 32'h0, 1'b0);
            #1;
            if (c == 3) begin
                n_vec++;
                if (stall !== 6'b000000) begin
                    n_err++; $display("FAIL rst_stall: got %b expected 000000", stall);
                end
            end
            if (c == 4) begin
                n_vec++;
                if (stall !== 6'b001111 || stall_timeout_sticky !== 1'b0) begin
                    n_err++; $display("FAIL rst_release: got stall=%b sticky=%b expected 001111/0", stall, stall_timeout_sticky);
                end
            end
            if (c >= 4) begin
                n_vec++;
                if (stall_timeout !== (c == 8)) begin
                    n_err++; $display("FAIL rst_wd_restart cycle %0d: got %b expected %b", c, stall_timeout, (c == 8));
                end
            end
        end
        drive(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 4'b1111, 1'b1, 32'h0000_0008, 32'h0, 1'b0);
        drive(1'b0, 4'b1111, 1'b1, 32'h0000_000E, 32'h1234_5678, 1'b0);
        #1; n_vec++;
        if (flush !== 1'b1 || new_pc !== 32'h1234_5678 || stall !== 6'b000000) begin
            n_err++; $display("FAIL b2b_eret: got flush=%b new_pc=%h stall=%b expected 1/12345678/000000", flush, new_pc, stall);
        end
        for (int c = 0; c < 60; c++) begin
            drive(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 1) == 0) ? 32'h0000_000E : 32'h0000_0004,
                  $urandom, ($urandom_range(0, 7) == 0));
        end
        drive(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_stall_priority();
        test_exception();
        test_watchdog();
        test_reset_mid_stall();
        test_back_to_back();
        @(negedge clk);
        #2;
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++; $display("FAIL sb_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
